// File: rtl/vlog_fsm_gear_pkg.sv
// vlog_fsm_gear_pkg: state encoding and named constants shared by the gear sequencer
package vlog_fsm_gear_pkg;
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      TAXI  = 3'd0,
      TUP   = 3'd1,
      TDN   = 3'd2,
      GOUP  = 3'd3,
      GODN  = 3'd4,
      FLYUP = 3'd5,
      FLYDN = 3'd6,
      FAULT = 3'd7
   } state_t;
   localparam logic YES   = 1'b1;
   localparam logic NO    = 1'b0;
   localparam logic ON    = 1'b1;
   localparam logic OFF   = 1'b0;
   localparam logic UP    = 1'b0;
   localparam logic DOWN  = 1'b1;
   localparam logic RESET = 1'b1;
   localparam logic COUNT = 1'b0;
endpackage

// File: rtl/vlog_fsm_gear_ctrl_if.sv
// vlog_fsm_gear_ctrl_if: cockpit/sensor side and actuator/LED side of the gear sequencer
interface vlog_fsm_gear_ctrl_if #(parameter int NUM_GEAR = 3);
   logic [NUM_GEAR-1:0] GearIsDown;
   logic [NUM_GEAR-1:0] GearIsUp;
   logic                PlaneOnGround;
   logic                Lever;
   logic                FaultAck;
   logic                RedLED;
   logic                GrnLED;
   logic                Valve;
   logic                Pump;
   logic                Fault;
   logic [2:0]          StateOut;
   modport master (
      output GearIsDown, GearIsUp, PlaneOnGround, Lever, FaultAck,
      input  RedLED, GrnLED, Valve, Pump, Fault, StateOut
   );
   modport slave (
      input  GearIsDown, GearIsUp, PlaneOnGround, Lever, FaultAck,
      output RedLED, GrnLED, Valve, Pump, Fault, StateOut
   );
endinterface

// File: rtl/vlog_fsm_gear_debounce.sv
// vlog_fsm_gear_debounce: per-bit filter, output bit follows only after 3 identical raw samples
import vlog_fsm_gear_pkg::*;
module vlog_fsm_gear_debounce #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
)(
   input  logic         Clock,
   input  logic         Clear,
   input  logic [W-1:0] raw,
   output logic [W-1:0] filt
);
   logic [W-1:0] s1, s2;
   always_ff @(posedge Clock) begin
      if (Clear) begin
         s1   <= RST_VAL;
         s2   <= RST_VAL;
         filt <= RST_VAL;
      end else begin
         s1   <= raw;
         s2   <= s1;
         // all three ones -> 1, all three zeros -> 0, any disagreement -> hold
         filt <= (raw & s1 & s2) | (filt & (raw | s1 | s2));
      end
   end
endmodule

// File: rtl/vlog_fsm_gear_ctrl.sv
// vlog_fsm_gear_ctrl: landing-gear sequencer with takeoff/motion timers and fault recovery
// Define GEAR_DEBOUNCE_EN to filter the gear and weight-on-wheels sensors.
import vlog_fsm_gear_pkg::*;
module vlog_fsm_gear_ctrl #(
   parameter int NUM_GEAR       = 3,
   parameter int TIMER_W        = 16,
   parameter int TAKEOFF_CYCLES = 2000,
   parameter int MOTION_TIMEOUT = 50000
)(
   input logic                 Clock,
   input logic                 Clear,
   vlog_fsm_gear_ctrl_if.slave bus
);
   logic [NUM_GEAR-1:0] down, up;
   logic                ground;
`ifdef GEAR_DEBOUNCE_EN
   vlog_fsm_gear_debounce #(.W(NUM_GEAR), .RST_VAL({NUM_GEAR{1'b1}})) u_down (
      .Clock(Clock), .Clear(Clear), .raw(bus.GearIsDown), .filt(down));
   vlog_fsm_gear_debounce #(.W(NUM_GEAR), .RST_VAL('0)) u_up (
      .Clock(Clock), .Clear(Clear), .raw(bus.GearIsUp), .filt(up));
   vlog_fsm_gear_debounce #(.W(1), .RST_VAL(1'b1)) u_ground (
      .Clock(Clock), .Clear(Clear), .raw(bus.PlaneOnGround), .filt(ground));
`else
   assign down   = bus.GearIsDown;
   assign up     = bus.GearIsUp;
   assign ground = bus.PlaneOnGround;
`endif
   state_t               state, nxt;
   logic [TIMER_W-1:0]   timer, timer_nxt;
   logic                 tmr_op;
   logic                 all_down, all_up, conflict, time_up, motion_to;
   assign all_down  = &down;
   assign all_up    = &up;
   assign conflict  = |(down & up);
   assign time_up   = timer >= TIMER_W'(TAKEOFF_CYCLES);
   assign motion_to = timer >= TIMER_W'(MOTION_TIMEOUT);
   assign bus.StateOut = state;
   always_comb begin
      nxt = state;
      case (state)
         TAXI:     nxt = ground ? TAXI : (bus.Lever == UP) ? TUP : TDN;
         TUP, TDN: nxt = ground ? TAXI : conflict ? FAULT : !all_down ? GOUP :
                         time_up ? FLYDN : (bus.Lever == UP) ? TUP : TDN;
         GOUP:     nxt = (conflict || motion_to) ? FAULT : all_up ? FLYUP : GOUP;
         GODN:     nxt = (conflict || motion_to) ? FAULT : (all_down && ground) ? TAXI :
                         all_down ? FLYDN : GODN;
         FLYUP:    nxt = conflict ? FAULT : (bus.Lever == DOWN) ? GODN : FLYUP;
         FLYDN:    nxt = conflict ? FAULT : ground ? TAXI : (bus.Lever == UP) ? GOUP : FLYDN;
         FAULT:    nxt = !bus.FaultAck ? FAULT : (all_down && ground) ? TAXI :
                         all_down ? FLYDN : all_up ? FLYUP : GODN;
         default:  nxt = FAULT;
      endcase
   end
   // TUP<->TDN swaps keep counting so the takeoff grace is not restarted by lever play
   always_comb begin
      tmr_op    = (nxt == TAXI || (nxt != state && nxt inside {GOUP, GODN, FAULT})) ? RESET : COUNT;
      timer_nxt = (tmr_op == RESET) ? '0 : (&timer) ? timer : timer + 1'b1;
   end
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state      <= TAXI;
         timer      <= '0;
         bus.RedLED <= OFF;
         bus.GrnLED <= ON;
         bus.Valve  <= DOWN;
         bus.Pump   <= OFF;
         bus.Fault  <= NO;
      end else begin
         state      <= nxt;
         timer      <= timer_nxt;
         bus.RedLED <= (nxt inside {GOUP, GODN, FAULT}) ? ON : OFF;
         bus.GrnLED <= (nxt inside {TAXI, TUP, TDN, FLYDN}) ? ON : OFF;
         bus.Valve  <= (nxt == FAULT) ? bus.Valve : (nxt inside {TUP, GOUP, FLYUP}) ? UP : DOWN;
         bus.Pump   <= (nxt inside {GOUP, GODN}) ? ON : OFF;
         bus.Fault  <= (nxt == FAULT) ? YES : NO;
      end
   end
endmodule

// File: doc/vlog_fsm_gear_ctrl.md
Name: vlog_fsm_gear_ctrl

Overview:
Parametrised landing-gear sequencer for NUM_GEAR independent legs. It takes a per-leg up/down sensor vector, the gear lever and the weight-on-wheels input, and drives the hydraulic valve/pump and the cockpit LEDs. It runs its own takeoff-grace and gear-motion timers and adds fault detection, a FAULT state and acknowledge-based recovery. It sits between the cockpit I/O and the hydraulic actuator drivers.

Parameters:
NUM_GEAR, 3, number of gear legs; must be at least 1.
TIMER_W, 16, width of the internal timer.
TAKEOFF_CYCLES, 2000, grace period after leaving TAXI; must be less than 2**TIMER_W.
MOTION_TIMEOUT, 50000, maximum cycles allowed in GOUP or GODN; must be less than 2**TIMER_W.

Ports:
Clock  in  1  system clock; all logic on the rising edge.
Clear  in  1  synchronous, active-high reset.
GearIsDown  in  NUM_GEAR  per-leg down-and-locked sensor.
GearIsUp  in  NUM_GEAR  per-leg up-and-locked sensor.
PlaneOnGround  in  1  weight-on-wheels.
Lever  in  1  gear lever; 1 = DOWN, 0 = UP.
FaultAck  in  1  single-cycle pulse that clears FAULT.
RedLED  out  1  gear in transit or fault.
GrnLED  out  1  gear down and safe.
Valve  out  1  1 = DOWN, 0 = UP.
Pump  out  1  hydraulic pump enable.
Fault  out  1  high while in FAULT.
StateOut  out  3  current state encoding, for debug.

Behaviour:
- Reset: Clear is sampled on the Clock edge and is synchronous, active-high. It forces State = TAXI and timer = 0. It takes priority over every other input, including mid-motion and in FAULT.
- Reset output values: RedLED=0, GrnLED=1, Valve=1, Pump=0, Fault=0, StateOut=TAXI.
- Outputs are registered Moore outputs, decoded from next-state. They change on the same edge as State; there is no output lag.
- Derived signals:
  - AllDown = &GearIsDown; AllUp = &GearIsUp.
  - Conflict = |(GearIsDown & GearIsUp), i.e. any leg reporting both up and down.
  - TimeUp = (timer >= TAKEOFF_CYCLES).
  - MotionTO = (timer >= MOTION_TIMEOUT).
- Timer: held at 0 in TAXI. Cleared on entry to GOUP, GODN and FAULT. Otherwise it increments by one per cycle and saturates at 2**TIMER_W-1. Moving between TUP and TDN does not clear it.
- States and outputs, listed as Red/Grn/Valve/Pump:
  - TAXI: 0/1/1/0.
  - TUP: 0/1/0/0.
  - TDN: 0/1/1/0.
  - GOUP: 1/0/0/1.
  - GODN: 1/0/1/1.
  - FLYUP: 0/0/0/0.
  - FLYDN: 0/1/1/0.
  - FAULT: 1/0/hold last Valve/0, with Fault=1.
- Transitions (priority top-down within each state):
  - TAXI: if !PlaneOnGround and Lever=UP go to TUP; if !PlaneOnGround and Lever=DOWN go to TDN; otherwise stay.
  - TUP/TDN:
    - PlaneOnGround goes to TAXI.
    - Conflict goes to FAULT.
    - !AllDown goes to GOUP.
    - TimeUp goes to FLYDN.
    - Lever change swaps TUP and TDN.
    - Otherwise stay.
  - GOUP: Conflict or MotionTO goes to FAULT; AllUp goes to FLYUP; otherwise stay.
  - GODN:
    - Conflict or MotionTO goes to FAULT.
    - AllDown and PlaneOnGround goes to TAXI.
    - AllDown goes to FLYDN.
    - Otherwise stay.
  - FLYUP: Conflict goes to FAULT; Lever=DOWN goes to GODN; otherwise stay.
  - FLYDN:
    - Conflict goes to FAULT.
    - PlaneOnGround goes to TAXI.
    - Lever=UP goes to GOUP.
    - Otherwise stay.
  - FAULT: stays until FaultAck, then:
    - AllDown and PlaneOnGround: TAXI.
    - AllDown: FLYDN.
    - AllUp: FLYUP.
    - Otherwise: GODN, always retrying with gear down.
  - FaultAck has no effect outside FAULT.
- Simultaneous events: Clear beats everything. Conflict beats timeout and completion in the same cycle.
- Any illegal State encoding goes to FAULT on the next edge.

Optional Feature:
GEAR_DEBOUNCE_EN
- Defined: GearIsDown, GearIsUp and PlaneOnGround each pass through a filter. A filtered bit updates only after 3 consecutive identical raw samples. This adds 3 cycles of input latency. Filters reset to down=all-1, up=0, ground=1.
- Undefined: raw inputs are used directly with no added latency.

Decomposition:
- Package vlog_fsm_gear_pkg holds:
  - the state localparams: TAXI=0, TUP=1, TDN=2, GOUP=3, GODN=4, FLYUP=5, FLYDN=6, FAULT=7;
  - the YES/NO, ON/OFF, UP/DOWN and RESET/COUNT constants;
  - the state width.
- One sub-module, vlog_fsm_gear_debounce, is a per-bit 3-sample filter parametrised by width. It is instantiated only under GEAR_DEBOUNCE_EN.

Test Plan:
All scenarios use NUM_GEAR=3, TAKEOFF_CYCLES=4, MOTION_TIMEOUT=8, macro undefined.
1. Clear high for 2 cycles -> TAXI, RedLED=0, GrnLED=1, Valve=1, Pump=0, Fault=0.
2. PlaneOnGround=0, Lever=0, GearIsDown=3'b111 -> TUP next edge with Valve=0; after 4 more cycles -> FLYDN, then GOUP on the following edge.
3. In GOUP, GearIsUp=3'b111 on cycle 5 -> FLYUP, Pump=0, RedLED=0, GrnLED=0.
4. In GOUP, GearIsUp held at 3'b011 -> FAULT after 8 cycles, Fault=1, Pump=0; FaultAck with GearIsDown=3'b111 and PlaneOnGround=0 -> FLYDN, Fault=0.
5. In FLYUP, set Lever=1 -> GODN; then GearIsDown=3'b111 with PlaneOnGround=1 -> TAXI, with the timer reading 0.
6. In FLYDN, GearIsDown=3'b001 with GearIsUp=3'b001 -> FAULT next edge. Separately, Clear asserted mid-GODN -> TAXI on the next edge.
